// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state type and alignment helpers.
// Consumers: lsu_mem_ctrl, lsu_load_extract.
package riscv_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } l_func_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } s_func_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        RESP
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        unique case (size)
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic       st,
                                        input logic [2:0] f3);
        logic ill;
        if (st) begin
            ill = (f3 > 3'b010);
        end else begin
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return ill;
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        unique case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] repl_wdata(input logic [1:0]  size,
                                               input logic [31:0] wd);
        logic [31:0] r;
        unique case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load lane select and sign/zero extension over a two-word little-endian
// window; the byte offset picks the first byte of the access.
module lsu_load_extract
    import riscv_pkg::*;
(
    input  logic [63:0] win_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] w;

    always_comb begin
        w      = win_i[{off_i, 3'b000} +: 32];
        data_o = w;
        unique case (l_func_e'(funct3_i))
            LB:      data_o = {{24{w[7]}}, w[7:0]};
            LH:      data_o = {{16{w[15]}}, w[15:0]};
            LW:      data_o = w;
            LBU:     data_o = {24'h000000, w[7:0]};
            LHU:     data_o = {16'h0000, w[15:0]};
            default: data_o = w;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store sequencer onto a request/grant data-memory port.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two.
module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [3:0]        be1_q;
    logic [31:0]       wd1_q;
    logic [31:0]       word0_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       rdata_q;
    logic              fault_q;
    logic              stall_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    logic [1:0]        off_w;
    logic [1:0]        size_w;
    logic              bad_w;
    logic              split_w;
    logic [3:0]        be0_w;
    logic [3:0]        be1_w;
    logic [31:0]       wd0_w;
    logic [31:0]       wd1_w;
    logic [63:0]       win_w;
    logic [31:0]       ext_w;
    logic              tmo_w;

    assign off_w  = addr[1:0];
    assign size_w = funct3[1:0];
    assign tmo_w  = (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]  mask_w;
    logic [63:0] wsh_w;

    always_comb begin
        mask_w  = {4'b0000, size_mask(size_w)} << off_w;
        wsh_w   = {32'h0, wdata} << {off_w, 3'b000};
        be0_w   = mask_w[3:0];
        be1_w   = mask_w[7:4];
        split_w = |mask_w[7:4];
        wd1_w   = wsh_w[63:32];
        bad_w   = is_illegal(is_store, funct3);
        wd0_w   = repl_wdata(size_w, wdata);
        if (is_misaligned(size_w, off_w)) begin
            wd0_w = wsh_w[31:0];
        end
    end
`else
    always_comb begin
        be0_w   = size_mask(size_w) << off_w;
        be1_w   = 4'b0000;
        split_w = 1'b0;
        wd0_w   = repl_wdata(size_w, wdata);
        wd1_w   = 32'h0;
        bad_w   = is_illegal(is_store, funct3) ||
                  is_misaligned(size_w, off_w);
    end
`endif

    // Second beat supplies the upper word of the window.
    assign win_w = (state_q == WAIT2) ? {mem_rdata, word0_q}
                                      : {32'h0, mem_rdata};

    lsu_load_extract u_extract (
        .win_i    (win_w),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ext_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            split_q      <= 1'b0;
            be1_q        <= 4'b0000;
            wd1_q        <= 32'h0;
            word0_q      <= 32'h0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b0;
            stall_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q     <= is_store;
                        f3_q        <= funct3;
                        off_q       <= off_w;
                        split_q     <= split_w;
                        be1_q       <= be1_w;
                        wd1_q       <= wd1_w;
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        cnt_q       <= '0;
                        if (bad_w) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b1;
                            rdata_q      <= 32'h0;
                        end else begin
                            state_q     <= REQ1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be0_w;
                            mem_wdata_q <= wd0_w;
                        end
                    end
                end
                REQ1, REQ2: begin
                    if (mem_gnt) begin
                        state_q   <= (state_q == REQ1) ? WAIT1 : WAIT2;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (tmo_w) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        fault_q      <= 1'b1;
                        rdata_q      <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT1, WAIT2: begin
                    if (mem_rvalid) begin
                        word0_q <= mem_rdata;
                        cnt_q   <= '0;
                        if (state_q == WAIT1 && split_q) begin
                            state_q     <= REQ2;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                            mem_be_q    <= be1_q;
                            mem_wdata_q <= wd1_q;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b0;
                            rdata_q      <= store_q ? 32'h0 : ext_w;
                        end
                    end else if (tmo_w) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        fault_q      <= 1'b1;
                        rdata_q      <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rdata_q     <= 32'h0;
                    fault_q     <= 1'b0;
                    stall_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;
    assign stall      = stall_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a bench-driven memory responder.
// Split-mode expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_ctrl;

    localparam int TO = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          is_store = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          fault;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .fault      (fault),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic        gnt_on = 1'b1;
    int          r_cyc, r_nreq, r_reqcyc;
    logic [31:0] r_rdata;
    logic        r_fault, r_ready, r_resp2;
    logic [31:0] r_addr [2];
    logic [3:0]  r_be   [2];
    logic        r_we   [2];
    logic [31:0] r_wd   [2];

    task automatic run(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] w0, input logic [31:0] w1);
        logic        pend;
        logic [31:0] words [2];
        words[0] = w0;
        words[1] = w1;
        pend     = 1'b0;
        r_cyc    = -1;
        r_nreq   = 0;
        r_reqcyc = 0;
        r_rdata  = 32'hx;
        r_fault  = 1'bx;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = 32'h0;
            r_be[i]   = 4'h0;
            r_we[i]   = 1'b0;
            r_wd[i]   = 32'h0;
        end
        @(negedge clk);
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (resp_valid) begin
                r_cyc   = c;
                r_rdata = rdata;
                r_fault = fault;
                break;
            end
            if (mem_req) r_reqcyc++;
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = words[(r_nreq - 1) % 2];
                pend       = 1'b0;
            end else if (mem_req && gnt_on) begin
                if (r_nreq < 2) begin
                    r_addr[r_nreq] = mem_addr;
                    r_be[r_nreq]   = mem_be;
                    r_we[r_nreq]   = mem_we;
                    r_wd[r_nreq]   = mem_wdata;
                end
                r_nreq++;
                mem_gnt = 1'b1;
                pend    = 1'b1;
            end
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        r_resp2    = resp_valid;
        r_ready    = req_ready;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_mreq", mem_req, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_fault", fault, 0);
        chk("rst_be", mem_be, 0);
        reset = 1'b0;

        run(0, 3'b000, 32'h00100002, 0, 32'hF1F2F3F4, 0);
        chk("lb_addr", r_addr[0], 32'h00100000);
        chk("lb_be", r_be[0], 4'b0100);
        chk("lb_we", r_we[0], 0);
        chk("lb_rdata", r_rdata, 32'hFFFFFFF2);
        chk("lb_fault", r_fault, 0);

        run(0, 3'b100, 32'h00100002, 0, 32'hF1F2F3F4, 0);
        chk("lbu_rdata", r_rdata, 32'h000000F2);

        run(0, 3'b001, 32'h00100002, 0, 32'hF1F2F3F4, 0);
        chk("lh_be", r_be[0], 4'b1100);
        chk("lh_rdata", r_rdata, 32'hFFFFF1F2);

        run(0, 3'b101, 32'h00100002, 0, 32'hF1F2F3F4, 0);
        chk("lhu_rdata", r_rdata, 32'h0000F1F2);

        run(0, 3'b010, 32'h00100000, 0, 32'hF1F2F3F4, 0);
        chk("lw_rdata", r_rdata, 32'hF1F2F3F4);
        chk("lw_be", r_be[0], 4'b1111);
        chk("lw_lat", r_cyc, 3);
        chk("lw_resp1", r_resp2, 0);
        chk("lw_ready", r_ready, 1);

        run(1, 3'b000, 32'h00100003, 32'h000000AB, 32'hDEADBEEF, 0);
        chk("sb_we", r_we[0], 1);
        chk("sb_be", r_be[0], 4'b1000);
        chk("sb_wdata", r_wd[0], 32'hABABABAB);
        chk("sb_rdata", r_rdata, 0);
        chk("sb_fault", r_fault, 0);

        run(1, 3'b001, 32'h00100002, 32'h00001234, 0, 0);
        chk("sh_be", r_be[0], 4'b1100);
        chk("sh_wdata", r_wd[0], 32'h12341234);

        run(1, 3'b010, 32'h00100000, 32'hCAFEBABE, 0, 0);
        chk("sw_be", r_be[0], 4'b1111);
        chk("sw_wdata", r_wd[0], 32'hCAFEBABE);

        run(0, 3'b010, 32'h00100002, 0, 32'hF1F2F3F4, 32'h11223344);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("mis_nreq", r_nreq, 2);
        chk("mis_addr0", r_addr[0], 32'h00100000);
        chk("mis_be0", r_be[0], 4'b1100);
        chk("mis_addr1", r_addr[1], 32'h00100004);
        chk("mis_be1", r_be[1], 4'b0011);
        chk("mis_rdata", r_rdata, 32'h3344F1F2);
        chk("mis_fault", r_fault, 0);
        chk("mis_lat", r_cyc, 5);
`else
        chk("mis_nreq", r_nreq, 0);
        chk("mis_reqcyc", r_reqcyc, 0);
        chk("mis_fault", r_fault, 1);
        chk("mis_rdata", r_rdata, 0);
        chk("mis_lat", r_cyc, 1);
`endif

        run(0, 3'b110, 32'h00100000, 0, 32'h12345678, 0);
        chk("ill_ld_fault", r_fault, 1);
        chk("ill_ld_nreq", r_nreq, 0);

        run(1, 3'b011, 32'h00100000, 32'h1, 0, 0);
        chk("ill_st_fault", r_fault, 1);
        chk("ill_st_nreq", r_nreq, 0);

        gnt_on = 1'b0;
        run(0, 3'b010, 32'h00100008, 0, 0, 0);
        gnt_on = 1'b1;
        chk("to_fault", r_fault, 1);
        chk("to_reqcyc", r_reqcyc, TO);
        chk("to_lat", r_cyc, TO + 1);
        chk("to_resp1", r_resp2, 0);
        chk("to_ready", r_ready, 1);

        @(negedge clk);
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h00100004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rw_mreq", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_stall", stall, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_mreq0", mem_req, 0);
        chk("rw_stall0", stall, 0);
        chk("rw_resp0", resp_valid, 0);
        chk("rw_ready", req_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rw_resp_post", resp_valid, 0);

        run(0, 3'b010, 32'h00100004, 0, 32'h55667788, 0);
        chk("rw_lw_rdata", r_rdata, 32'h55667788);
        chk("rw_lw_addr", r_addr[0], 32'h00100004);
        chk("rw_lw_lat", r_cyc, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
